// File: rtl/cpu_step_ctrl.sv
// Execution controller for the single-cycle core: turns the run switch, step
// button and a PC breakpoint into one-cycle clock-enable pulses.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned RUN_DIV         = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_run,
  input  logic        btn_step_n,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic        halted,
  output logic [15:0] step_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W  = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_RUN,
    ST_BRK
  } state_t;

  logic             mode_meta;
  logic             mode_s;
  logic             btn_meta;
  logic             btn_s;
  logic             btn_stable;
  logic             btn_stable_d;
  logic [DB_W-1:0]  db_cnt;
  logic             press_evt;
  logic [DIV_W-1:0] div;
  state_t           state;
  logic             term_c;
  logic             bp_hit_c;

  // Two-stage synchronizers for the asynchronous board inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_meta <= 1'b0;
      mode_s    <= 1'b0;
      btn_meta  <= 1'b1;
      btn_s     <= 1'b1;
    end else begin
      mode_meta <= mode_run;
      mode_s    <= mode_meta;
      btn_meta  <= btn_step_n;
      btn_s     <= btn_meta;
    end
  end

  // Debounce: accept a level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_stable   <= 1'b1;
      btn_stable_d <= 1'b1;
      db_cnt       <= '0;
      press_evt    <= 1'b0;
    end else begin
      if (btn_s == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= btn_s;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      btn_stable_d <= btn_stable;
      press_evt    <= btn_stable_d & ~btn_stable;
    end
  end

  assign term_c   = (div == DIV_LAST);
  assign bp_hit_c = bp_en && (pc == bp_addr);

  // Control FSM; a breakpoint hit suppresses the pulse so that instruction is not executed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HALT;
      div        <= '0;
      cpu_en     <= 1'b0;
      halted     <= 1'b1;
      step_count <= '0;
    end else begin
      cpu_en     <= 1'b0;
      step_count <= step_count + CNT_W'(cpu_en);
      unique case (state)
        ST_HALT: begin
          cpu_en <= press_evt;
          if (mode_s) begin
            state  <= ST_RUN;
            halted <= 1'b0;
            div    <= '0;
          end
        end
        ST_RUN: begin
          if (!mode_s) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (term_c) begin
            div <= '0;
            if (bp_hit_c) begin
              state  <= ST_BRK;
              halted <= 1'b1;
            end else begin
              cpu_en <= 1'b1;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        ST_BRK: begin
          cpu_en <= press_evt;
          if (!mode_s) begin
            state <= ST_HALT;
          end
        end
        default: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: a latency-based reference model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_cpu_step_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned R = 5;
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_BRK  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_run = 1'b0;
  logic        btn_step_n = 1'b1;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        cpu_en;
  logic        halted;
  logic [15:0] step_count;

  int n_vec  = 0;
  int n_fail = 0;
  bit preload = 1'b0;

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_run   (mode_run),
    .btn_step_n (btn_step_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  // Core stand-in: advances PC by one instruction on every enable pulse
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) pc = 32'h0;
    else if (cpu_en) pc = pc + 32'd4;
  end

  // Reference model: raw inputs reach the logic two edges late; a press is acted on
  // two edges after the debounced level falls; run pulses land every R edges after entry.
  bit          mode_h1 = 1'b0, mode_h2 = 1'b0;
  bit          btn_h1 = 1'b1, btn_h2 = 1'b1;
  bit          m_stable = 1'b1;
  int          m_diff_run = 0;
  bit          m_press_valid = 1'b0;
  int          m_press_due = 0;
  int          m_k = 0;
  int          m_entry = 0;
  int          m_state = M_HALT;
  logic        m_en = 1'b0;
  logic        m_halted = 1'b1;
  logic [15:0] m_count = 16'h0;
  bit          mode_seen, btn_seen, press_now, pulse;
  int          nxt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_h1 = 1'b0; mode_h2 = 1'b0; btn_h1 = 1'b1; btn_h2 = 1'b1;
      m_stable = 1'b1; m_diff_run = 0; m_press_valid = 1'b0; m_press_due = 0;
      m_k = 0; m_entry = 0; m_state = M_HALT;
      m_en = 1'b0; m_halted = 1'b1; m_count = 16'h0;
    end else begin
      m_k++;
      mode_seen = mode_h2;
      btn_seen  = btn_h2;
      press_now = m_press_valid && (m_press_due == m_k);
      if (btn_seen != m_stable) begin
        m_diff_run++;
        if (m_diff_run == int'(D)) begin
          m_stable   = btn_seen;
          m_diff_run = 0;
          if (!m_stable) begin
            m_press_valid = 1'b1;
            m_press_due   = m_k + 2;
          end
        end
      end else begin
        m_diff_run = 0;
      end
      pulse = 1'b0;
      nxt   = m_state;
      case (m_state)
        M_HALT: begin
          pulse = press_now;
          if (mode_seen) begin nxt = M_RUN; m_entry = m_k; end
        end
        M_RUN: begin
          if (!mode_seen) nxt = M_HALT;
          else if (((m_k - m_entry) % int'(R)) == 0) begin
            if (bp_en && pc == bp_addr) nxt = M_BRK;
            else pulse = 1'b1;
          end
        end
        default: begin
          pulse = press_now;
          if (!mode_seen) nxt = M_HALT;
        end
      endcase
      m_count  = preload ? 16'hFFFD : m_count + 16'(m_en);
      m_en     = pulse;
      m_halted = (nxt != M_RUN);
      m_state  = nxt;
      mode_h2 = mode_h1; mode_h1 = mode_run;
      btn_h2  = btn_h1;  btn_h1  = btn_step_n;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model
  task automatic tick();
    @(negedge clk);
    if (!preload) begin
      check("model_cpu_en", 32'(cpu_en), 32'(m_en));
      check("model_halted", 32'(halted), 32'(m_halted));
      check("model_step_count", 32'(step_count), 32'(m_count));
    end
  endtask

  int n;
  int at;
  int last;

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) tick();
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_count", 32'(step_count), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Glitch shorter than the debounce window, then a clean press
    n = 0;
    btn_step_n = 1'b0;
    tick(); tick();
    btn_step_n = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); if (cpu_en) n++; end
    check("glitch_pulses", 32'(n), 32'd0);
    n = 0; at = 0;
    btn_step_n = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cpu_en) begin n++; at = i; end
      if (i == 10) btn_step_n = 1'b1;
    end
    check("step_pulses", 32'(n), 32'd1);
    check("step_latency", 32'(at), 32'd8);
    for (int i = 0; i < 6; i++) tick();
    check("step_count_1", 32'(step_count), 32'd1);

    // Free run with a button press that must be ignored
    mode_run = 1'b1; n = 0; last = -1;
    for (int i = 1; i <= 28; i++) begin
      tick();
      if (cpu_en) begin
        if (last >= 0) check("run_gap", 32'(i - last), 32'd5);
        last = i; n++;
      end
      if (i == 3) btn_step_n = 1'b0;
      if (i == 11) btn_step_n = 1'b1;
      if (i == 15) check("run_halted", 32'(halted), 32'd0);
    end
    check("run_pulses", 32'(n), 32'd5);
    check("run_first", 32'(cpu_en), 32'd1);

    // Asynchronous reset mid-cycle while running
    #2 rst_n = 1'b0; mode_run = 1'b0;
    #1;
    check("arst_cpu_en", 32'(cpu_en), 32'd0);
    check("arst_halted", 32'(halted), 32'd1);
    check("arst_count", 32'(step_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Breakpoint at 0xC, step past it, then resume through HALT
    bp_en = 1'b1; bp_addr = 32'h0000_000C; mode_run = 1'b1; n = 0;
    for (int i = 1; i <= 30; i++) begin tick(); if (cpu_en) n++; end
    check("bp_pulses", 32'(n), 32'd3);
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_pc", pc, 32'h0000_000C);
    n = 0;
    btn_step_n = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (cpu_en) n++;
      if (i == 10) btn_step_n = 1'b1;
    end
    check("brk_step_pulses", 32'(n), 32'd1);
    check("brk_still_halted", 32'(halted), 32'd1);
    mode_run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("brk_to_halt", 32'(halted), 32'd1);
    mode_run = 1'b1; n = 0;
    for (int i = 1; i <= 10; i++) begin tick(); if (cpu_en) n++; end
    check("resume_pulses", 32'(n), 32'd1);
    check("resume_halted", 32'(halted), 32'd0);

    // Halt request landing on the terminal-count cycle
    bp_en = 1'b0; mode_run = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    mode_run = 1'b1; n = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 8) check("tc_first_pulse", 32'(cpu_en), 32'd1);
      if (i > 8 && cpu_en) n++;
      if (i == 10) mode_run = 1'b0;
      if (i == 12) check("tc_still_run", 32'(halted), 32'd0);
      if (i == 13) begin
        check("tc_no_pulse", 32'(cpu_en), 32'd0);
        check("tc_halted", 32'(halted), 32'd1);
      end
    end
    check("tc_extra_pulses", 32'(n), 32'd0);

    // Counter wrap: preload near the top, then let run mode carry it over
    @(negedge clk);
    preload = 1'b1;
    force dut.step_count = 16'hFFFD;
    @(negedge clk);
    release dut.step_count;
    preload = 1'b0;
    mode_run = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 14) check("wrap_ffff", 32'(step_count), 32'h0000_FFFF);
      if (i == 19) check("wrap_zero", 32'(step_count), 32'h0000_0000);
    end
    check("wrap_one", 32'(step_count), 32'h0000_0001);
    mode_run = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
